// File: rtl/cpu_control.sv
// cpu_control: multi-cycle LC-3b control sequencer.
// Walks fetch/decode/execute/memory/writeback, driving every datapath load and
// select line plus the memory strobes. Memory stalls are bounded by a wait
// counter; an expired wait latches mem_error and parks the FSM in HALT.

package lc3b_types;
    typedef enum logic [2:0] {
        alu_add,
        alu_and,
        alu_not,
        alu_pass,
        alu_sll,
        alu_srl,
        alu_sra
    } lc3b_aluop;
endpackage

module cpu_control
    import lc3b_types::*;
#(
    parameter int WAIT_LIMIT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       branch_enable,
    input  logic       imm5_enable,
    input  logic       offset11_enable,
    input  logic       d_bit,
    input  logic       a_bit,
    input  logic       mem_addr0,
    input  logic       mem_resp,
    output logic       load_pc,
    output logic       load_ir,
    output logic       load_regfile,
    output logic       load_mar,
    output logic       load_mdr,
    output logic       load_cc,
    output logic [1:0] pcmux_sel,
    output logic [1:0] alumux_sel,
    output logic [1:0] regfilemux_sel,
    output logic [1:0] marmux_sel,
    output logic [1:0] loadmux_sel,
    output logic       storemux_sel,
    output logic       mdrmux_sel,
    output logic       pcoffsetmux_sel,
    output logic       maradjmux_sel,
    output lc3b_aluop  aluop,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] mem_byte_enable,
    output logic       mem_error
);

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LDB  = 4'b0010;
    localparam logic [3:0] OP_STB  = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_SHF  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    // Counter wide enough to hold WAIT_LIMIT itself (saturation value).
    localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT_VAL = CW'(WAIT_LIMIT);
    localparam logic [CW-1:0] LAST_WAIT = (WAIT_LIMIT > 0) ? CW'(WAIT_LIMIT - 1) : '0;

    // Three distinct read states so the read's successor needs no extra flag:
    // MEMRD (operand data), MEMRD_PTR (LDI/STI pointer), MEMRD_TRAP (vector).
    typedef enum logic [4:0] {
        FETCH1, FETCH2, FETCH3, DECODE,
        S_ALU, S_NOT, S_SHF, S_LEA,
        BR_TAKEN, S_JMP, JSR1, JSR2,
        CALC, MEMRD, MEMRD_PTR, IND, STR1, MEMWR, WB,
        TRAP1, TRAP2, MEMRD_TRAP, TRAP3, HALT
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
    logic          mem_error_reg, mem_error_next;
    logic          mem_state;
    logic          timeout_hit;

    assign mem_state = (state_reg == FETCH2) || (state_reg == MEMRD) ||
                       (state_reg == MEMRD_PTR) || (state_reg == MEMRD_TRAP) ||
                       (state_reg == MEMWR);

    // Final stalled cycle allowed: this one also lacks mem_resp, so give up.
    assign timeout_hit = (WAIT_LIMIT != 0) && mem_state && !mem_resp &&
                         (wait_cnt_reg == LAST_WAIT);

    assign mem_error = mem_error_reg;

    // State, wait counter and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= FETCH1;
            wait_cnt_reg  <= '0;
            mem_error_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            mem_error_reg <= mem_error_next;
        end
    end

    // Wait counter counts stalled memory cycles, clears everywhere else.
    always_comb begin
        wait_cnt_next  = '0;
        mem_error_next = mem_error_reg | timeout_hit;
        if ((WAIT_LIMIT != 0) && mem_state && !mem_resp) begin
            wait_cnt_next = (wait_cnt_reg == LIMIT_VAL) ? wait_cnt_reg
                                                        : wait_cnt_reg + CW'(1);
        end
    end

    // Next-state and Moore control outputs; defaults first, then per state.
    always_comb begin
        state_next      = state_reg;
        load_pc         = 1'b0;
        load_ir         = 1'b0;
        load_regfile    = 1'b0;
        load_mar        = 1'b0;
        load_mdr        = 1'b0;
        load_cc         = 1'b0;
        pcmux_sel       = 2'd0;
        alumux_sel      = 2'd0;
        regfilemux_sel  = 2'd0;
        marmux_sel      = 2'd0;
        loadmux_sel     = 2'd0;
        storemux_sel    = 1'b0;
        mdrmux_sel      = 1'b0;
        pcoffsetmux_sel = 1'b0;
        maradjmux_sel   = 1'b0;
        aluop           = alu_pass;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 2'b11;

        case (state_reg)
            FETCH1: begin
                marmux_sel = 2'd1;
                load_mar   = 1'b1;
                load_pc    = 1'b1;
                pcmux_sel  = 2'd0;
                state_next = FETCH2;
            end
            FETCH2: begin
                mem_read   = 1'b1;
                mdrmux_sel = 1'b1;
                load_mdr   = 1'b1;
                if (mem_resp)         state_next = FETCH3;
                else if (timeout_hit) state_next = HALT;
            end
            FETCH3: begin
                load_ir    = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_ADD, OP_AND: state_next = S_ALU;
                    OP_NOT:         state_next = S_NOT;
                    OP_SHF:         state_next = S_SHF;
                    OP_LEA:         state_next = S_LEA;
                    OP_BR:          state_next = branch_enable ? BR_TAKEN : FETCH1;
                    OP_JMP:         state_next = S_JMP;
                    OP_JSR:         state_next = JSR1;
                    OP_LDR, OP_LDB, OP_STR, OP_STB, OP_LDI, OP_STI:
                                    state_next = CALC;
                    OP_TRAP:        state_next = TRAP1;
                    default:        state_next = FETCH1;
                endcase
            end
            S_ALU: begin
                alumux_sel   = imm5_enable ? 2'd2 : 2'd0;
                aluop        = (opcode == OP_AND) ? alu_and : alu_add;
                load_regfile = 1'b1;
                load_cc      = 1'b1;
                state_next   = FETCH1;
            end
            S_NOT: begin
                aluop        = alu_not;
                load_regfile = 1'b1;
                load_cc      = 1'b1;
                state_next   = FETCH1;
            end
            S_SHF: begin
                alumux_sel   = 2'd3;
                aluop        = !d_bit ? alu_sll : (a_bit ? alu_sra : alu_srl);
                load_regfile = 1'b1;
                load_cc      = 1'b1;
                state_next   = FETCH1;
            end
            S_LEA: begin
                regfilemux_sel = 2'd2;
                loadmux_sel    = 2'd2;
                load_regfile   = 1'b1;
                load_cc        = 1'b1;
                state_next     = FETCH1;
            end
            BR_TAKEN: begin
                pcmux_sel       = 2'd1;
                pcoffsetmux_sel = 1'b0;
                load_pc         = 1'b1;
                state_next      = FETCH1;
            end
            S_JMP: begin
                pcmux_sel  = 2'd2;
                load_pc    = 1'b1;
                state_next = FETCH1;
            end
            JSR1: begin
                regfilemux_sel = 2'd3;
                load_regfile   = 1'b1;
                state_next     = JSR2;
            end
            JSR2: begin
                if (offset11_enable) begin
                    pcmux_sel       = 2'd1;
                    pcoffsetmux_sel = 1'b1;
                end else begin
                    pcmux_sel = 2'd2;
                end
                load_pc    = 1'b1;
                state_next = FETCH1;
            end
            CALC: begin
                // Byte accesses address through the MAR adjust path; word
                // accesses use the ALU to add the scaled offset.
                if (opcode == OP_LDB || opcode == OP_STB) begin
                    marmux_sel    = 2'd3;
                    maradjmux_sel = 1'b1;
                end else begin
                    alumux_sel = 2'd1;
                    aluop      = alu_add;
                end
                load_mar = 1'b1;
                case (opcode)
                    OP_LDR, OP_LDB: state_next = MEMRD;
                    OP_STR, OP_STB: state_next = STR1;
                    default:        state_next = MEMRD_PTR;
                endcase
            end
            MEMRD, MEMRD_PTR, MEMRD_TRAP: begin
                mem_read   = 1'b1;
                mdrmux_sel = 1'b1;
                load_mdr   = 1'b1;
                if (mem_resp) begin
                    if (state_reg == MEMRD)          state_next = WB;
                    else if (state_reg == MEMRD_PTR) state_next = IND;
                    else                             state_next = TRAP3;
                end else if (timeout_hit) begin
                    state_next = HALT;
                end
            end
            IND: begin
                marmux_sel = 2'd2;
                load_mar   = 1'b1;
                state_next = (opcode == OP_LDI) ? MEMRD : STR1;
            end
            STR1: begin
                storemux_sel = 1'b1;
                aluop        = alu_pass;
                load_mdr     = 1'b1;
                state_next   = MEMWR;
            end
            MEMWR: begin
                mem_write = 1'b1;
                if (opcode == OP_STB) begin
                    mem_byte_enable = mem_addr0 ? 2'b10 : 2'b01;
                end
                if (mem_resp)         state_next = FETCH1;
                else if (timeout_hit) state_next = HALT;
            end
            WB: begin
                if (opcode == OP_LDB) begin
                    regfilemux_sel = 2'd2;
                    loadmux_sel    = {1'b0, mem_addr0};
                end else begin
                    regfilemux_sel = 2'd1;
                end
                load_regfile = 1'b1;
                load_cc      = 1'b1;
                state_next   = FETCH1;
            end
            TRAP1: begin
                regfilemux_sel = 2'd3;
                load_regfile   = 1'b1;
                state_next     = TRAP2;
            end
            TRAP2: begin
                marmux_sel    = 2'd3;
                maradjmux_sel = 1'b0;
                load_mar      = 1'b1;
                state_next    = MEMRD_TRAP;
            end
            TRAP3: begin
                // Vector sits in MDR; route it to the PC input.
                marmux_sel = 2'd2;
                pcmux_sel  = 2'd2;
                load_pc    = 1'b1;
                state_next = FETCH1;
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = FETCH1;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_control.sv
// tb_cpu_control: directed plus randomized instruction stream for cpu_control.
// A behavioural memory answers strobes after a chosen number of wait cycles;
// each instruction's observed control activity is compared with what the
// instruction should do according to an instruction-level reference table.

module tb_cpu_control;
    import lc3b_types::*;

    localparam int WL = 4;

    localparam logic [3:0] OP_BR   = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_LDB  = 4'h2;
    localparam logic [3:0] OP_STB  = 4'h3;
    localparam logic [3:0] OP_JSR  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_LDR  = 4'h6;
    localparam logic [3:0] OP_STR  = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_STI  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_SHF  = 4'hD;
    localparam logic [3:0] OP_LEA  = 4'hE;
    localparam logic [3:0] OP_TRAP = 4'hF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] opcode;
    logic       branch_enable, imm5_enable, offset11_enable, d_bit, a_bit;
    logic       mem_addr0, mem_resp;
    logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
    logic [1:0] pcmux_sel, alumux_sel, regfilemux_sel, marmux_sel, loadmux_sel;
    logic       storemux_sel, mdrmux_sel, pcoffsetmux_sel, maradjmux_sel;
    lc3b_aluop  aluop;
    logic       mem_read, mem_write;
    logic [1:0] mem_byte_enable;
    logic       mem_error;

    cpu_control #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .branch_enable(branch_enable),
        .imm5_enable(imm5_enable), .offset11_enable(offset11_enable),
        .d_bit(d_bit), .a_bit(a_bit), .mem_addr0(mem_addr0), .mem_resp(mem_resp),
        .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
        .load_mar(load_mar), .load_mdr(load_mdr), .load_cc(load_cc),
        .pcmux_sel(pcmux_sel), .alumux_sel(alumux_sel),
        .regfilemux_sel(regfilemux_sel), .marmux_sel(marmux_sel),
        .loadmux_sel(loadmux_sel), .storemux_sel(storemux_sel),
        .mdrmux_sel(mdrmux_sel), .pcoffsetmux_sel(pcoffsetmux_sel),
        .maradjmux_sel(maradjmux_sel), .aluop(aluop), .mem_read(mem_read),
        .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_error(mem_error)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural memory state
    bit in_ep;
    int ep_idx, ep_wait, acc_idx;
    bit auto_resp;
    int waits [4];

    // Per-instruction observations
    int cyc, n_rd, n_wr, n_wr_cyc, n_rf, n_cc, n_pc, n_ir, n_overlap, first_rf;
    logic [1:0] rf_sel, ld_sel, pc_sel, alu_sel, be_obs;
    logic       pcoff_obs;
    lc3b_aluop  aluop_obs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample at the falling edge and play the memory side.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (mem_read || mem_write) begin
            if (!in_ep) begin
                in_ep   = 1'b1;
                ep_idx  = 0;
                ep_wait = (acc_idx < 4) ? waits[acc_idx] : 0;
                acc_idx++;
                if (mem_read) n_rd++;
                else          n_wr++;
            end
            if (auto_resp && ep_idx == ep_wait) begin
                mem_resp = 1'b1;
                in_ep    = 1'b0;
            end else begin
                mem_resp = 1'b0;
            end
            ep_idx++;
        end else begin
            in_ep    = 1'b0;
            mem_resp = 1'b0;
        end
    endtask

    function automatic bit at_fetch1();
        return load_mar && (marmux_sel == 2'd1) && load_pc && (pcmux_sel == 2'd0);
    endfunction

    // Run one instruction starting with the DUT observed in FETCH1.
    task automatic exec_instr(input logic [3:0] op, input logic imm5, input logic off11,
                              input logic d, input logic a, input logic br,
                              input logic addr0, input int w0, input int w1, input int w2);
        int extra = 0, e_rd = 1, e_wr = 0, e_rf = 0, e_cc = 0, e_pc = 0;
        int e_cyc, e_wrcyc, n_acc;
        bit e_alu = 1'b0, done = 1'b0;
        logic [1:0] e_rfsel = 2'd0, e_pcsel = 2'd0, e_alumux = 2'd0, e_be = 2'b11, e_ldsel = 2'd0;
        logic e_pcoff = 1'b0;
        lc3b_aluop e_aluop = alu_pass;
        string tag;

        // Instruction-level reference: what each instruction must cause.
        case (op)
            OP_ADD, OP_AND: begin
                extra = 1; e_rf = 1; e_cc = 1; e_alu = 1'b1;
                e_alumux = imm5 ? 2'd2 : 2'd0;
                e_aluop  = (op == OP_AND) ? alu_and : alu_add;
            end
            OP_NOT: begin extra = 1; e_rf = 1; e_cc = 1; e_alu = 1'b1; e_aluop = alu_not; end
            OP_SHF: begin
                extra = 1; e_rf = 1; e_cc = 1; e_alu = 1'b1; e_alumux = 2'd3;
                e_aluop = !d ? alu_sll : (a ? alu_sra : alu_srl);
            end
            OP_LEA:  begin extra = 1; e_rf = 1; e_cc = 1; e_rfsel = 2'd2; e_ldsel = 2'd2; end
            OP_BR:   if (br) begin extra = 1; e_pc = 1; e_pcsel = 2'd1; end
            OP_JMP:  begin extra = 1; e_pc = 1; e_pcsel = 2'd2; end
            OP_JSR:  begin
                extra = 2; e_rf = 1; e_rfsel = 2'd3; e_pc = 1;
                e_pcsel = off11 ? 2'd1 : 2'd2; e_pcoff = off11;
            end
            OP_LDR:  begin extra = 2; e_rd = 2; e_rf = 1; e_cc = 1; e_rfsel = 2'd1; end
            OP_LDB:  begin extra = 2; e_rd = 2; e_rf = 1; e_cc = 1; e_rfsel = 2'd2; e_ldsel = {1'b0, addr0}; end
            OP_STR:  begin extra = 2; e_wr = 1; end
            OP_STB:  begin extra = 2; e_wr = 1; e_be = addr0 ? 2'b10 : 2'b01; end
            OP_LDI:  begin extra = 3; e_rd = 3; e_rf = 1; e_cc = 1; e_rfsel = 2'd1; end
            OP_STI:  begin extra = 3; e_rd = 2; e_wr = 1; end
            OP_TRAP: begin extra = 3; e_rd = 2; e_rf = 1; e_rfsel = 2'd3; e_pc = 1; e_pcsel = 2'd2; end
            default: ;
        endcase
        waits[0] = w0; waits[1] = w1; waits[2] = w2; waits[3] = 0;
        n_acc   = e_rd + e_wr;
        e_cyc   = 3 + extra;
        for (int i = 0; i < n_acc; i++) e_cyc += waits[i] + 1;
        e_wrcyc = (e_wr > 0) ? waits[n_acc - 1] + 1 : 0;

        opcode = op; imm5_enable = imm5; offset11_enable = off11;
        d_bit = d; a_bit = a; branch_enable = br; mem_addr0 = addr0;
        acc_idx = 0; auto_resp = 1'b1;
        cyc = 1; n_rd = 0; n_wr = 0; n_wr_cyc = 0; n_rf = 0; n_cc = 0; n_pc = 0;
        n_ir = 0; n_overlap = 0; first_rf = -1;
        rf_sel = 2'd0; ld_sel = 2'd0; pc_sel = 2'd0; alu_sel = 2'd0; be_obs = 2'b11;
        pcoff_obs = 1'b0; aluop_obs = alu_pass;

        for (int k = 0; k < 100; k++) begin
            tick();
            if (at_fetch1()) begin done = 1'b1; break; end
            if (mem_read && mem_write) n_overlap++;
            if (mem_write) begin n_wr_cyc++; be_obs = mem_byte_enable; end
            if (load_ir) n_ir++;
            if (load_regfile) begin
                n_rf++; rf_sel = regfilemux_sel; ld_sel = loadmux_sel;
                if (first_rf < 0) first_rf = cyc;
            end
            if (load_cc) begin n_cc++; alu_sel = alumux_sel; aluop_obs = aluop; end
            if (load_pc) begin n_pc++; pc_sel = pcmux_sel; pcoff_obs = pcoffsetmux_sel; end
            cyc++;
        end

        tag = $sformatf("op%0h", op);
        check({tag, "_back_to_fetch"}, 32'(done), 32'd1);
        check({tag, "_cycles"}, cyc, e_cyc);
        check({tag, "_reads"}, n_rd, e_rd);
        check({tag, "_writes"}, n_wr, e_wr);
        check({tag, "_write_cycles"}, n_wr_cyc, e_wrcyc);
        check({tag, "_rd_wr_overlap"}, n_overlap, 0);
        check({tag, "_load_ir"}, n_ir, 1);
        check({tag, "_load_regfile"}, n_rf, e_rf);
        check({tag, "_load_cc"}, n_cc, e_cc);
        check({tag, "_load_pc"}, n_pc, e_pc);
        if (e_rf > 0) check({tag, "_regfilemux"}, 32'(rf_sel), 32'(e_rfsel));
        if (op == OP_LDB || op == OP_LEA) check({tag, "_loadmux"}, 32'(ld_sel), 32'(e_ldsel));
        if (e_pc > 0) begin
            check({tag, "_pcmux"}, 32'(pc_sel), 32'(e_pcsel));
            check({tag, "_pcoffsetmux"}, 32'(pcoff_obs), 32'(e_pcoff));
        end
        if (e_alu) begin
            check({tag, "_alumux"}, 32'(alu_sel), 32'(e_alumux));
            check({tag, "_aluop"}, 32'(aluop_obs), 32'(e_aluop));
            check({tag, "_wb_cycle"}, first_rf, 4 + w0);
        end
        if (e_wr > 0) check({tag, "_byte_enable"}, 32'(be_obs), 32'(e_be));
        $display("instr op=%h imm5=%0b off11=%0b d=%0b a=%0b br=%0b a0=%0b waits=%0d/%0d/%0d cycles=%0d",
                 op, imm5, off11, d, a, br, addr0, w0, w1, w2, cyc);
    endtask

    initial begin
        bit done;
        int strobe_cyc, activity;

        rst = 1'b1; opcode = 4'h0; branch_enable = 1'b0; imm5_enable = 1'b0;
        offset11_enable = 1'b0; d_bit = 1'b0; a_bit = 1'b0; mem_addr0 = 1'b0;
        mem_resp = 1'b0; in_ep = 1'b0; auto_resp = 1'b1; acc_idx = 0;
        ep_idx = 0; ep_wait = 0;
        for (int i = 0; i < 4; i++) waits[i] = 0;

        // Reset state: FETCH1 with MAR loaded from PC, no strobes, no error.
        repeat (2) @(negedge clk);
        check("reset_fetch1", 32'(at_fetch1()), 32'd1);
        check("reset_mem_read", 32'(mem_read), 32'd0);
        check("reset_mem_write", 32'(mem_write), 32'd0);
        check("reset_mem_error", 32'(mem_error), 32'd0);
        check("reset_byte_enable", 32'(mem_byte_enable), 32'd3);
        $display("reset released");
        rst = 1'b0;

        // Directed instructions
        exec_instr(OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        exec_instr(OP_BR,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        exec_instr(OP_BR,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 0);
        exec_instr(OP_STB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 2, 0);
        exec_instr(OP_LDI, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 2, 2);
        exec_instr(OP_SHF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        exec_instr(OP_JSR, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        exec_instr(OP_TRAP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 3, 0);

        // Randomized instruction stream (waits stay below the timeout limit)
        for (int n = 0; n < 80; n++) begin
            exec_instr(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), $urandom_range(0, WL - 1),
                       $urandom_range(0, WL - 1), $urandom_range(0, WL - 1));
        end

        // Reset held 2 cycles in the middle of an LDR data read
        opcode = OP_LDR; auto_resp = 1'b1; acc_idx = 0; n_rd = 0; n_wr = 0;
        waits[0] = 0; waits[1] = 3; waits[2] = 0; waits[3] = 0;
        done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (n_rd == 2) begin done = 1'b1; break; end
        end
        check("rst_reach_memrd", 32'(done), 32'd1);
        check("rst_memrd_strobe", 32'(mem_read), 32'd1);
        auto_resp = 1'b0; mem_resp = 1'b0; rst = 1'b1;
        tick();
        check("rst_mid_mem_read", 32'(mem_read), 32'd0);
        check("rst_mid_fetch1", 32'(at_fetch1()), 32'd1);
        check("rst_mid_mem_error", 32'(mem_error), 32'd0);
        tick();
        rst = 1'b0; auto_resp = 1'b1;
        $display("reset during read done");
        exec_instr(OP_NOT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 0);

        // Memory never answers: timeout after WL stall cycles, then HALT
        opcode = OP_ADD; auto_resp = 1'b0; acc_idx = 0;
        strobe_cyc = 0; done = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (mem_error) begin done = 1'b1; break; end
            if (mem_read) strobe_cyc++;
        end
        check("timeout_error_set", 32'(done), 32'd1);
        check("timeout_stall_cycles", strobe_cyc, WL);
        check("timeout_read_dropped", 32'(mem_read), 32'd0);
        check("timeout_write_low", 32'(mem_write), 32'd0);
        activity = 0;
        repeat (10) begin
            tick();
            if (mem_read || mem_write || load_pc || load_mar || load_mdr ||
                load_ir || load_regfile || load_cc) activity++;
            if (!mem_error) activity++;
        end
        check("halt_quiet_sticky", activity, 0);
        $display("timeout halt observed");
        rst = 1'b1;
        tick();
        check("halt_reset_error_clear", 32'(mem_error), 32'd0);
        check("halt_reset_fetch1", 32'(at_fetch1()), 32'd1);
        rst = 1'b0; auto_resp = 1'b1;
        exec_instr(OP_AND, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
